// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline datapath (master) and the
// stall/flush sequencer (slave). HAZ_PERF_CNT_EN adds the performance counters.
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       mem_access;
    logic       dmem_ready;
    logic       mem_branch_taken;
    logic       pc_write;
    logic       pc_sel_branch;
    logic       if_id_write;
    logic       id_ex_write;
    logic       ex_mem_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       mem_wb_flush;
    logic       mem_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, mem_access, dmem_ready, mem_branch_taken,
        input  pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write,
        input  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err
`ifdef HAZ_PERF_CNT_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read, mem_access, dmem_ready, mem_branch_taken,
        output pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write,
        output if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err
`ifdef HAZ_PERF_CNT_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: memory wait with timeout,
// branch flush and load-use stall. Optional perf counters under HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic             mem_err_q, mem_err_nxt;
    logic             load_use;

    logic pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs1) || (hz.ex_rd == hz.id_rs2));

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_err_nxt   = 1'b0;
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        mem_wb_flush  = 1'b0;

        case (state)
            RUN: begin
                if (hz.mem_access && !hz.dmem_ready) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_flush = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNT_W'(1);
                end else if (hz.mem_branch_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                mem_wb_flush = 1'b1;
                if (hz.dmem_ready) begin
                    // Completed access is let through into MEM/WB.
                    mem_wb_flush = 1'b0;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == LAST_CNT) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    mem_err_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase

        if (rst) begin
            pc_write      = 1'b0;
            pc_sel_branch = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            mem_wb_flush  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write)     stall_cycles_q <= stall_cycles_q + 32'd1;
            if (pc_sel_branch) flush_count_q  <= flush_count_q + 32'd1;
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`endif

    assign hz.pc_write      = pc_write;
    assign hz.pc_sel_branch = pc_sel_branch;
    assign hz.if_id_write   = if_id_write;
    assign hz.id_ex_write   = id_ex_write;
    assign hz.ex_mem_write  = ex_mem_write;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_flush  = ex_mem_flush;
    assign hz.mem_wb_flush  = mem_wb_flush;
    assign hz.mem_err       = mem_err_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, then random stimulus
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 4;

    // Output vector: {pc_write, pc_sel_branch, if_id_write, id_ex_write, ex_mem_write,
    //                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err}
    localparam logic [9:0] O_RST  = 10'b0_0_000_1111_0;
    localparam logic [9:0] O_IDLE = 10'b1_0_111_0000_0;
    localparam logic [9:0] O_LU   = 10'b0_0_011_0100_0;
    localparam logic [9:0] O_BR   = 10'b1_1_111_1110_0;
    localparam logic [9:0] O_MW   = 10'b0_0_000_0001_0;
    localparam logic [9:0] O_MR   = 10'b0_0_000_0000_0;
    localparam logic [9:0] O_ERR  = 10'b1_0_111_0000_1;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       ld;
        logic       ma;
        logic       rdy;
        logic       br;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: whether an access is pending, how many stall cycles the
    // current access has already cost, and whether an error pulse is due.
    bit waiting    = 1'b0;
    int stalls     = 0;
    bit err_due    = 1'b0;
    int m_stall_cycles = 0;
    int m_flushes      = 0;

    function automatic logic [9:0] model_out(input in_t v);
        logic [9:0] o;
        if (v.rst)
            o = O_RST;
        else if (waiting || (v.ma && !v.rdy))
            o = (waiting && v.rdy) ? O_MR : O_MW;
        else if (v.br)
            o = O_BR;
        else if (v.ld && v.rd != 0 && (v.rd == v.rs1 || v.rd == v.rs2))
            o = O_LU;
        else
            o = O_IDLE;
        o[0] = err_due;
        return o;
    endfunction

    task automatic model_update(input in_t v, input logic [9:0] o);
        if (v.rst) begin
            waiting = 1'b0; stalls = 0; err_due = 1'b0;
            m_stall_cycles = 0; m_flushes = 0;
        end else begin
            err_due = 1'b0;
            if (!o[9]) m_stall_cycles++;
            if (o[8])  m_flushes++;
            if (!waiting) begin
                if (v.ma && !v.rdy) begin waiting = 1'b1; stalls = 1; end
            end else if (v.rdy) begin
                waiting = 1'b0;
            end else if (stalls + 1 == MEM_TIMEOUT) begin
                waiting = 1'b0; err_due = 1'b1;
            end else begin
                stalls++;
            end
        end
    endtask

    task automatic drive(input in_t v);
        rst                 = v.rst;
        hz.id_rs1           = v.rs1;
        hz.id_rs2           = v.rs2;
        hz.ex_rd            = v.rd;
        hz.ex_mem_read      = v.ld;
        hz.mem_access       = v.ma;
        hz.dmem_ready       = v.rdy;
        hz.mem_branch_taken = v.br;
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
    task automatic step(input in_t v, input bit use_exp, input logic [9:0] exp, input string name);
        logic [9:0] m, got;
        @(negedge clk);
        drive(v);
        #1;
        m   = model_out(v);
        got = {hz.pc_write, hz.pc_sel_branch, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
               hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush, hz.mem_err};
        check(name, got, use_exp ? exp : m);
        @(posedge clk);
        model_update(v, m);
    endtask

    function automatic in_t mk(input logic r, input int rs1, input int rs2, input int rd,
                               input logic ld, input logic ma, input logic rdy, input logic br);
        in_t v;
        v.rst = r; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.ld = ld; v.ma = ma; v.rdy = rdy; v.br = br;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // Reset, load-use, branch priority, memory wait with ready, and timeout.
        tbl.push_back('{mk(1, 5, 5, 5, 1, 1, 0, 1), O_RST});
        tbl.push_back('{mk(1, 9, 3, 3, 1, 1, 1, 0), O_RST});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{mk(0, 1, 5, 5, 1, 0, 0, 0), O_LU});
        tbl.push_back('{mk(0, 0, 0, 0, 1, 0, 0, 0), O_IDLE});
        tbl.push_back('{mk(0, 7, 2, 7, 1, 0, 0, 0), O_LU});
        tbl.push_back('{mk(0, 7, 2, 7, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 1, 0), O_IDLE});
        tbl.push_back('{mk(0, 5, 2, 5, 1, 0, 0, 1), O_BR});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 0), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 1), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 0), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 1, 1), O_MR});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 0, 0, 1), O_BR});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 0, 0, 0), O_IDLE});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 0), O_MW});
        tbl.push_back('{mk(0, 4, 2, 4, 1, 1, 0, 0), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 0), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 1, 0, 1), O_MW});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 0, 0, 0), O_ERR});
        tbl.push_back('{mk(0, 1, 2, 3, 0, 0, 0, 0), O_IDLE});

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);

        foreach (tbl[i])
            step(tbl[i].in, 1'b1, tbl[i].exp, $sformatf("table[%0d]", i));

        // Timeout back-to-back with a new stalled access in the error cycle.
        for (int i = 0; i < MEM_TIMEOUT; i++)
            step(mk(0, 1, 2, 3, 0, 1, 0, 0), 1'b1, O_MW, $sformatf("seq_to_a[%0d]", i));
        step(mk(0, 1, 2, 3, 0, 1, 0, 0), 1'b1, O_MW | 10'b1, "seq_to_reenter");
        step(mk(0, 1, 2, 3, 0, 1, 1, 0), 1'b1, O_MR, "seq_to_ready");
        step(mk(0, 1, 2, 3, 0, 0, 0, 0), 1'b1, O_IDLE, "seq_to_idle");

        for (int i = 0; i < 400; i++) begin
            in_t v;
            v.rst = ($urandom_range(0, 39) == 0);
            v.rs1 = 5'($urandom_range(0, 5));
            v.rs2 = 5'($urandom_range(0, 5));
            v.rd  = 5'($urandom_range(0, 5));
            v.ld  = 1'($urandom_range(0, 1));
            v.ma  = ($urandom_range(0, 3) == 0);
            v.rdy = ($urandom_range(0, 2) == 0);
            v.br  = ($urandom_range(0, 4) == 0);
            step(v, 1'b0, 10'b0, $sformatf("rand[%0d]", i));
        end

`ifdef HAZ_PERF_CNT_EN
        #1;
        vectors++;
        if (hz.stall_cycles !== 32'(m_stall_cycles)) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d expected %0d", hz.stall_cycles, m_stall_cycles);
        end
        vectors++;
        if (hz.flush_count !== 32'(m_flushes)) begin
            miscompares++;
            $display("FAIL flush_count: got %0d expected %0d", hz.flush_count, m_flushes);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
